// File: rtl/shift_pkg.sv
`default_nettype none
// ==== shift_pkg : op codes, sequencer states, lowest-set-bit helper ==== rev 1.0
package shift_pkg;

  localparam logic [2:0] OP_SHR  = 3'd0;
  localparam logic [2:0] OP_SHRA = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_ROR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [2:0] lowest_set(input logic [4:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// ==== shift_stage : one shift/rotate by 2^k, purely combinational ==== rev 1.0
module shift_stage
  import shift_pkg::*;
(
  input  logic [31:0] din,
  input  logic [2:0]  op,
  input  logic [2:0]  k,
  input  logic        fill,
  output logic [31:0] dout
);

  logic [31:0] shr_v [5];
  logic [31:0] shl_v [5];
  logic [31:0] ror_v [5];
  logic [31:0] rol_v [5];

  for (genvar i = 0; i < 5; i++) begin : g_stage
    localparam int S = 1 << i;
    assign shr_v[i] = {{S{fill}}, din[31:S]};
    assign shl_v[i] = {din[31-S:0], {S{1'b0}}};
    assign ror_v[i] = {din[S-1:0], din[31:S]};
    assign rol_v[i] = {din[31-S:0], din[31:32-S]};
  end

  logic [31:0] shr_k, shl_k, ror_k, rol_k;

  always_comb begin
    shr_k = din;
    shl_k = din;
    ror_k = din;
    rol_k = din;
    for (int i = 0; i < 5; i++) begin
      if (k == 3'(i)) begin
        shr_k = shr_v[i];
        shl_k = shl_v[i];
        ror_k = ror_v[i];
        rol_k = rol_v[i];
      end
    end
  end

  // SHR and SHRA share one path; the caller drives fill low for SHR
  always_comb begin
    dout = din;
    case (op)
      OP_SHR, OP_SHRA: dout = shr_k;
      OP_SHL:          dout = shl_k;
      OP_ROR:          dout = ror_k;
      OP_ROL:          dout = rol_k;
      default:         dout = din;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ==== shift_sequencer : multi-cycle 32-bit shift/rotate, one 2^k stage per clock ==== rev 1.0
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [4:0]       pend, pend_n;
  logic [2:0]       op_q, op_q_n;
  logic             sign_q, sign_q_n;
  logic [2:0]       k;
  logic [WIDTH-1:0] stage_out;
  logic             fill;

  assign k    = lowest_set(pend);
  assign fill = (op_q == OP_SHRA) & sign_q;

  shift_stage u_stage (
    .din  (acc),
    .op   (op_q),
    .k    (k),
    .fill (fill),
    .dout (stage_out)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state  <= IDLE;
      acc    <= '0;
      pend   <= '0;
      op_q   <= '0;
      sign_q <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      pend   <= pend_n;
      op_q   <= op_q_n;
      sign_q <= sign_q_n;
      // result lands on the same edge that enters DONE
      if (state_n == DONE) result <= acc_n;
    end
  end

  always_comb begin
    state_n  = state;
    acc_n    = acc;
    pend_n   = pend;
    op_q_n   = op_q;
    sign_q_n = sign_q;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          op_q_n   = op;
          sign_q_n = a[WIDTH-1];
          acc_n    = a;
          pend_n   = b[4:0];
          state_n  = RUN;
          // Short-circuit cases finish without visiting RUN
          if (op > OP_ROL) begin
            acc_n   = '0;
            state_n = DONE;
          end else if (op <= OP_SHL && |b[WIDTH-1:5]) begin
            acc_n   = (op == OP_SHRA) ? {WIDTH{a[WIDTH-1]}} : '0;
            state_n = DONE;
          end else if (b[4:0] == 5'd0) begin
            state_n = DONE;
          end
        end
      end
      RUN: begin
        busy   = 1'b1;
        acc_n  = stage_out;
        pend_n = pend & ~(5'b00001 << k);
        if (pend_n == 5'd0) state_n = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ==== tb_shift_sequencer : directed + random checks against an arithmetic model ==== rev 1.0
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        clear;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(32)) dut (
    .clk    (clk),
    .clear  (clear),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  function automatic logic [31:0] model_result(input logic [2:0] o, input logic [31:0] x,
                                               input logic [31:0] amt);
    logic [63:0] dbl;
    logic [63:0] tmp;
    int          n;
    dbl = {x, x};
    n   = int'(amt % 32);
    case (o)
      3'd0: return (amt >= 32) ? 32'd0 : x >> amt;
      3'd1: return (amt >= 32) ? {32{x[31]}} : 32'($signed(x) >>> amt);
      3'd2: return (amt >= 32) ? 32'd0 : x << amt;
      3'd3: begin tmp = dbl >> n; return tmp[31:0]; end
      3'd4: begin tmp = dbl << n; return tmp[63:32]; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] o, input logic [31:0] amt);
    int n;
    int cnt;
    if (o > 3'd4) return 1;
    if (o <= 3'd2 && amt >= 32) return 1;
    n   = int'(amt % 32);
    cnt = 0;
    while (n > 0) begin
      cnt += n % 2;
      n   /= 2;
    end
    return 1 + cnt;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] amt,
                        input bit inject, input string tag);
    logic [31:0] er;
    int          lat;
    er  = model_result(o, x, amt);
    lat = model_latency(o, amt);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = amt;
    @(posedge clk);
    for (int c = 1; c <= lat + 2; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = inject && (lat >= 2);
        op    = 3'($urandom);
        a     = $urandom;
        b     = $urandom;
      end else begin
        start = 1'b0;
      end
      check({tag, "/done"}, 32'(done), 32'(c == lat));
      check({tag, "/busy"}, 32'(busy), 32'(c <= lat));
      if (c >= lat) check({tag, "/result"}, result, er);
    end
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ramt;
    clear = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset/busy",   32'(busy), 32'd0);
    check("reset/done",   32'(done), 32'd0);
    check("reset/result", result,    32'd0);
    clear = 1'b0;

    run_op(3'd2, 32'h0000_0001, 32'd5,  1'b0, "shl_1_5");
    run_op(3'd1, 32'h8000_0000, 32'd31, 1'b0, "shra_31");
    run_op(3'd1, 32'h8000_0000, 32'h40, 1'b0, "shra_big");
    run_op(3'd3, 32'h0000_00F1, 32'd36, 1'b0, "ror_36");
    run_op(3'd4, 32'h8000_0001, 32'd1,  1'b0, "rol_1");
    run_op(3'd0, 32'hFFFF_FFFF, 32'h20, 1'b0, "shr_big");
    run_op(3'd2, 32'hDEAD_BEEF, 32'd0,  1'b0, "shl_zero");
    run_op(3'd6, 32'h1234_5678, 32'd3,  1'b0, "op6");
    run_op(3'd2, 32'hA5A5_0F0F, 32'd22, 1'b1, "start_in_run");

    // clear during cycle 2 of a five-stage rotate drops the operation
    @(negedge clk);
    start = 1'b1;
    op    = 3'd4;
    a     = 32'hCAFE_F00D;
    b     = 32'd31;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear/busy",   32'(busy), 32'd0);
    check("clear/done",   32'(done), 32'd0);
    check("clear/result", result,    32'd0);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check("clear/no_done", 32'(done), 32'd0);
    end
    run_op(3'd3, 32'h0000_00F1, 32'd4, 1'b0, "after_clear");

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      case ($urandom % 4)
        0: ramt = 32'($urandom_range(0, 31));
        1: ramt = $urandom;
        2: ramt = 32'd32 | 32'($urandom_range(0, 31));
        default: ramt = 32'd31;
      endcase
      run_op(ro, $urandom, ramt, bit'($urandom % 2), $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
